inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//  Instruction fetch stage: owns the PC, issues word fetches to instruction memory, and buffers the returned words.
//  Presents inst_data_o/pc_o to decode (ImmGen, register file, control), gated by a valid/stall handshake.
//  Accepts taken branch/jal/jalr redirects from execute, and traps misaligned targets.
// PARAMETERS
//  RESET_PC   32'h0000_0000   PC loaded on reset; first fetch address
//  INST_NOP   32'h0000_0013   word driven on inst_data_o while inst_valid_o=0 (addi x0,x0,0)
// PORTS
//  clk_i          in   1   clock, rising edge
//  rst_i          in   1   synchronous reset, active-high
//  imem_req_o     out  1   fetch request; held until imem_ack_i
//  imem_addr_o    out  32  fetch byte address; stable while imem_req_o=1
//  imem_ack_i     in   1   memory returns imem_rdata_i this cycle (may coincide with req rise)
//  imem_rdata_i   in   32  fetched instruction word
//  redirect_i     in   1   taken control transfer; flush and refetch
//  redirect_pc_i  in   32  redirect target
//  stall_i        in   1   decode cannot accept; hold current instruction
//  inst_valid_o   out  1   inst_data_o/pc_o hold a real instruction
//  inst_data_o    out  32  instruction word to decode
//  pc_o           out  32  address of inst_data_o
//  pc_plus4_o     out  32  pc_o + 4 (jal/jalr link value)
//  misalign_o     out  1   sticky: redirect target had [1:0]!=0
// BEHAVIOUR
//  Reset (rst_i=1 at clk edge, any state, outstanding request abandoned): state=BOOT, fetch_pc=RESET_PC,
//   imem_req_o=0, inst_valid_o=0, inst_data_o=INST_NOP, pc_o=RESET_PC, pc_plus4_o=RESET_PC+4, misalign_o=0, skid empty.
//  FSM: BOOT -> FETCH (unconditional, 1 cycle). FETCH: imem_req_o=1 when skid empty, imem_addr_o=fetch_pc.
//   Once raised, req is never dropped before ack (except reset). On ack: fetch_pc += 4 (32-bit wrap, FFFF_FFFC -> 0).
//  Output buffering: OUT register plus one-entry SKID. Consume = inst_valid_o & ~stall_i.
//   Ack with OUT empty or consumed this cycle (and SKID empty) -> word to OUT.
//   Ack while OUT held (valid & stall) -> word to SKID. Consume with SKID full -> SKID to OUT, SKID empties.
//  Latency: ack in cycle N -> inst_valid_o=1 in N+1. Zero-wait memory + no stall -> one instruction per cycle.
//  Stall: OUT contents and pc_o constant while stall_i=1; at most one further word (in SKID) is fetched.
//  Redirect (highest priority after reset): OUT and SKID flushed (inst_valid_o=0 next cycle), fetch_pc <= redirect_pc_i.
//   If req outstanding and no ack this cycle -> DRAIN. DRAIN: req/addr held at old value until ack;
//   returned data discarded, then FETCH with new pc. An ack in the redirect cycle itself is discarded; state -> FETCH.
//   Redirect during DRAIN updates fetch_pc and stays in DRAIN. Redirect outranks stall_i.
//  Misaligned redirect (redirect_pc_i[1:0]!=0): misalign_o <= 1 (sticky until reset), flush as above.
//   Pass DRAIN if a request is outstanding, then HALT. HALT: imem_req_o=0, inst_valid_o=0; exits only by reset.
//  pc_plus4_o = pc_o + 4, 32-bit truncation. pc_o/pc_plus4_o change only when OUT loads.
// STRUCTURE
//  Shared package rv_fetch_pkg: state encodings (BOOT, FETCH, DRAIN, HALT), INST_NOP, PC_STEP=4, RESET_PC default.
//  Sub-module fetch_skid_buf: OUT+SKID two-entry buffer {pc, inst}, ports push/flush/consume/valid.
//  PC register and FSM stay in inst_fetch_unit.
// TESTING
//  1 Reset then zero-wait memory (ack same cycle), stall_i=0 -> addr 0,4,8 on consecutive cycles;
//    inst_valid_o=1 from cycle 2; pc_o 0,4,8.
//  2 Stall for 3 cycles with ack always high -> pc_o frozen at 0x8; exactly one extra fetch (0xC) into SKID;
//    release -> pc_o 0xC then 0x10 with no bubble.
//  3 1-wait-state memory, redirect_i to 0x100 while req to 0x10 pending -> req held at 0x10 until ack, data dropped,
//    next addr 0x100, first valid pc_o=0x100.
//  4 Redirect to 0x202 -> misalign_o=1 next cycle, inst_valid_o=0, imem_req_o=0 after drain;
//    stays until rst_i; after reset fetch resumes at RESET_PC.
//  5 rst_i during DRAIN with ack never returned -> all outputs at reset values next cycle; BOOT then FETCH at 0x0.
//  6 Redirect to 0xFFFF_FFFC -> fetched pc_o=FFFF_FFFC with pc_plus4_o=0; next fetch addr 0x0.

Source files
------------

// File: rtl/rv_fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : rv_fetch_pkg                                               |
// | Shared constants, state encodings and buffer entry type for the      |
// | instruction fetch stage.                                             |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package rv_fetch_pkg;

  // Fetch FSM encodings
  localparam logic [1:0] c_st_boot  = 2'd0;
  localparam logic [1:0] c_st_fetch = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;
  localparam logic [1:0] c_st_halt  = 2'd3;

  // addi x0,x0,0 shown to decode whenever no real instruction is present
  localparam logic [31:0] c_inst_nop = 32'h0000_0013;
  localparam logic [31:0] c_pc_step  = 32'd4;
  localparam logic [31:0] c_reset_pc = 32'h0000_0000;

  // One buffered instruction together with its address
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fetch_skid_buf                                             |
// | Two-entry output buffer (OUT + SKID) between instruction memory and  |
// | decode. SKID catches the one word that can land while OUT is held.  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module fetch_skid_buf
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = c_reset_pc,
  parameter logic [31:0] INST_NOP = c_inst_nop
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  fetch_entry_t i_push_entry,
  input  logic         i_flush,
  input  logic         i_consume,
  output logic         o_valid,
  output fetch_entry_t o_entry,
  output logic         o_skid_full
);

  fetch_entry_t r_out;
  fetch_entry_t r_skid;
  logic         r_out_valid;
  logic         r_skid_full;

  // OUT/SKID update: flush beats everything, SKID drains into OUT first on consume
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_skid_full <= 1'b0;
      r_out       <= '{pc: RESET_PC, inst: INST_NOP};
      r_skid      <= '{pc: RESET_PC, inst: INST_NOP};
    end else if (i_flush) begin
      // pc is left alone so pc_o only moves when OUT actually loads
      r_out_valid <= 1'b0;
      r_skid_full <= 1'b0;
    end else if (i_consume) begin
      if (r_skid_full) begin
        r_out       <= r_skid;
        r_out_valid <= 1'b1;
        r_skid_full <= i_push;
        if (i_push) begin
          r_skid <= i_push_entry;
        end
      end else if (i_push) begin
        r_out       <= i_push_entry;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (!r_out_valid) begin
      if (i_push) begin
        r_out       <= i_push_entry;
        r_out_valid <= 1'b1;
      end
    end else if (i_push) begin
      // OUT is held by decode: park the word in SKID
      r_skid      <= i_push_entry;
      r_skid_full <= 1'b1;
    end
  end

  assign o_valid     = r_out_valid;
  assign o_entry     = r_out;
  assign o_skid_full = r_skid_full;

endmodule
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : inst_fetch_unit                                            |
// | Instruction fetch stage: owns the PC, issues word fetches, buffers   |
// | returned words for decode, handles redirects and misaligned traps.   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module inst_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = c_reset_pc,
  parameter logic [31:0] INST_NOP = c_inst_nop
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_data_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        misalign_o
);

  logic [1:0]   r_state;
  logic [1:0]   w_state_next;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_drain_addr;
  logic         r_misalign;

  logic         w_ack;
  logic         w_redirect;
  logic         w_bad_target;
  logic         w_push;
  logic         w_consume;
  logic         w_buf_valid;
  logic         w_skid_full;
  fetch_entry_t w_buf_entry;
  fetch_entry_t w_push_entry;

  // Redirects are ignored once halted; only reset leaves HALT
  assign w_redirect   = redirect_i && (r_state != c_st_halt);
  assign w_bad_target = (redirect_pc_i[1:0] != 2'b00);
  assign w_ack        = imem_req_o && imem_ack_i;
  // Returned word is kept only in FETCH and only if not squashed this cycle
  assign w_push       = (r_state == c_st_fetch) && w_ack && !redirect_i;
  assign w_consume    = w_buf_valid && !stall_i;
  assign w_push_entry = '{pc: r_fetch_pc, inst: imem_rdata_i};

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= c_st_boot;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_boot: begin
        w_state_next = (w_redirect && w_bad_target) ? c_st_halt : c_st_fetch;
      end
      c_st_fetch: begin
        if (w_redirect) begin
          if (imem_req_o && !imem_ack_i) begin
            w_state_next = c_st_drain;
          end else if (w_bad_target) begin
            w_state_next = c_st_halt;
          end else begin
            w_state_next = c_st_fetch;
          end
        end
      end
      c_st_drain: begin
        if (w_ack) begin
          w_state_next = (r_misalign || (w_redirect && w_bad_target)) ? c_st_halt : c_st_fetch;
        end
      end
      default: begin
        w_state_next = c_st_halt;
      end
    endcase
  end

  // Memory request outputs: DRAIN keeps the abandoned request alive at its old address
  always_comb begin
    imem_req_o  = 1'b0;
    imem_addr_o = r_fetch_pc;
    case (r_state)
      c_st_fetch: begin
        imem_req_o = !w_skid_full;
      end
      c_st_drain: begin
        imem_req_o  = 1'b1;
        imem_addr_o = r_drain_addr;
      end
      default: begin
        imem_req_o = 1'b0;
      end
    endcase
  end

  // PC, drain address and sticky misalign flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fetch_pc   <= RESET_PC;
      r_drain_addr <= RESET_PC;
      r_misalign   <= 1'b0;
    end else begin
      if (w_redirect) begin
        r_fetch_pc <= redirect_pc_i;
      end else if (w_push) begin
        r_fetch_pc <= r_fetch_pc + c_pc_step;
      end
      if (w_redirect && (r_state == c_st_fetch)) begin
        r_drain_addr <= r_fetch_pc;
      end
      if (w_redirect && w_bad_target) begin
        r_misalign <= 1'b1;
      end
    end
  end

  fetch_skid_buf #(
    .RESET_PC (RESET_PC),
    .INST_NOP (INST_NOP)
  ) u_skid_buf (
    .clk          (clk_i),
    .rst          (rst_i),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_flush      (w_redirect),
    .i_consume    (w_consume),
    .o_valid      (w_buf_valid),
    .o_entry      (w_buf_entry),
    .o_skid_full  (w_skid_full)
  );

  assign inst_valid_o = w_buf_valid;
  assign inst_data_o  = w_buf_valid ? w_buf_entry.inst : INST_NOP;
  assign pc_o         = w_buf_entry.pc;
  assign pc_plus4_o   = w_buf_entry.pc + c_pc_step;
  assign misalign_o   = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_inst_fetch_unit                                         |
// | Self-checking bench for inst_fetch_unit: vector table, directed      |
// | corner sequences and a randomized run against a stream model.        |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_inst_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign;

  int n_err = 0;
  int n_chk = 0;

  inst_fetch_unit dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_ack_i    (imem_ack),
    .imem_rdata_i  (imem_rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .stall_i       (stall),
    .inst_valid_o  (inst_valid),
    .inst_data_o   (inst_data),
    .pc_o          (pc),
    .pc_plus4_o    (pc_plus4),
    .misalign_o    (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a distinct word per address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F01;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic rd, input logic [31:0] rp, input logic a);
    rst = r; stall = s; redirect = rd; redirect_pc = rp; imem_ack = a;
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic        rst, stall, redir;
    logic [31:0] rpc;
    logic        ack, chk, ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epc;
  } vec_t;

  vec_t vecs [14];

  // Randomized-run model state
  logic [31:0] exp_pc;
  logic        pend;
  logic [31:0] pend_addr;
  logic        hold;
  logic [31:0] hold_pc;
  int          n_consumed;
  logic        cons;

  initial begin
    // rst stall redir rpc ack | chk ereq eaddr valid pc
    vecs[0]  = '{1, 0, 0, 32'h0,         1, 0, 0, 32'h0,         0, 32'h0};
    vecs[1]  = '{0, 0, 0, 32'h0,         1, 1, 0, 32'h0,         0, 32'h0};
    vecs[2]  = '{0, 0, 0, 32'h0,         1, 1, 1, 32'h0,         0, 32'h0};
    vecs[3]  = '{0, 0, 0, 32'h0,         1, 1, 1, 32'h4,         1, 32'h0};
    vecs[4]  = '{0, 0, 0, 32'h0,         1, 1, 1, 32'h8,         1, 32'h4};
    vecs[5]  = '{0, 1, 0, 32'h0,         1, 1, 1, 32'hC,         1, 32'h8};
    vecs[6]  = '{0, 1, 0, 32'h0,         1, 1, 0, 32'h0,         1, 32'h8};
    vecs[7]  = '{0, 1, 0, 32'h0,         1, 1, 0, 32'h0,         1, 32'h8};
    vecs[8]  = '{0, 0, 0, 32'h0,         1, 1, 0, 32'h0,         1, 32'h8};
    vecs[9]  = '{0, 0, 0, 32'h0,         1, 1, 1, 32'h10,        1, 32'hC};
    vecs[10] = '{0, 0, 1, 32'hFFFF_FFFC, 1, 1, 1, 32'h14,        1, 32'h10};
    vecs[11] = '{0, 0, 0, 32'h0,         1, 1, 1, 32'hFFFF_FFFC, 0, 32'h10};
    vecs[12] = '{0, 0, 0, 32'h0,         1, 1, 1, 32'h0,         1, 32'hFFFF_FFFC};
    vecs[13] = '{0, 0, 0, 32'h0,         1, 1, 1, 32'h4,         1, 32'h0};

    // Zero-wait stream, stall with one SKID fetch, wrap-around redirect
    for (int i = 0; i < 14; i++) begin
      rst = vecs[i].rst; stall = vecs[i].stall; redirect = vecs[i].redir;
      redirect_pc = vecs[i].rpc; imem_ack = vecs[i].ack;
      if (vecs[i].chk) begin
        chk($sformatf("v%0d.req", i), {31'd0, imem_req}, {31'd0, vecs[i].ereq});
        if (vecs[i].ereq) chk($sformatf("v%0d.addr", i), imem_addr, vecs[i].eaddr);
        chk($sformatf("v%0d.valid", i), {31'd0, inst_valid}, {31'd0, vecs[i].evalid});
        chk($sformatf("v%0d.pc", i), pc, vecs[i].epc);
        chk($sformatf("v%0d.pc4", i), pc_plus4, vecs[i].epc + 32'd4);
        chk($sformatf("v%0d.data", i), inst_data, vecs[i].evalid ? mem_word(vecs[i].epc) : NOP);
        chk($sformatf("v%0d.misalign", i), {31'd0, misalign}, 32'd0);
      end
      @(posedge clk);
      @(negedge clk);
    end

    // One wait-state memory, redirect while the 0x10 request is pending
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1);
    end
    chk("ws.addr10", imem_addr, 32'h10);
    cyc(0, 0, 1, 32'h100, 0);
    chk("ws.drain_req", {31'd0, imem_req}, 32'd1);
    chk("ws.drain_addr", imem_addr, 32'h10);
    chk("ws.flush", {31'd0, inst_valid}, 32'd0);
    cyc(0, 0, 0, 0, 0);
    chk("ws.drain_addr2", imem_addr, 32'h10);
    cyc(0, 0, 0, 0, 1);
    chk("ws.dropped", {31'd0, inst_valid}, 32'd0);
    chk("ws.new_addr", imem_addr, 32'h100);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("ws.valid", {31'd0, inst_valid}, 32'd1);
    chk("ws.pc", pc, 32'h100);
    chk("ws.data", inst_data, mem_word(32'h100));

    // Misaligned redirect with a request outstanding: drain, then halt
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("ma.pc0", pc, 32'h0);
    cyc(0, 0, 1, 32'h202, 0);
    chk("ma.flag", {31'd0, misalign}, 32'd1);
    chk("ma.flush", {31'd0, inst_valid}, 32'd0);
    chk("ma.drain_addr", imem_addr, 32'h4);
    cyc(0, 0, 0, 0, 1);
    chk("ma.halt_req", {31'd0, imem_req}, 32'd0);
    cyc(0, 0, 1, 32'h300, 1);
    cyc(0, 0, 0, 0, 1);
    chk("ma.stay_req", {31'd0, imem_req}, 32'd0);
    chk("ma.stay_valid", {31'd0, inst_valid}, 32'd0);
    chk("ma.sticky", {31'd0, misalign}, 32'd1);
    cyc(1, 0, 0, 0, 0);
    chk("ma.rst_flag", {31'd0, misalign}, 32'd0);
    cyc(0, 0, 0, 0, 0);
    chk("ma.resume_req", {31'd0, imem_req}, 32'd1);
    chk("ma.resume_addr", imem_addr, 32'h0);

    // Reset while draining a request that never completes
    cyc(0, 0, 1, 32'h40, 0);
    chk("rd.drain_addr", imem_addr, 32'h0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rd.req", {31'd0, imem_req}, 32'd0);
    chk("rd.valid", {31'd0, inst_valid}, 32'd0);
    chk("rd.data", inst_data, NOP);
    chk("rd.pc", pc, 32'h0);
    chk("rd.pc4", pc_plus4, 32'h4);
    chk("rd.misalign", {31'd0, misalign}, 32'd0);
    cyc(0, 0, 0, 0, 0);
    chk("rd.fetch_req", {31'd0, imem_req}, 32'd1);
    chk("rd.fetch_addr", imem_addr, 32'h0);

    // Randomized run: delivered stream must follow pc+4 from each redirect target
    cyc(1, 0, 0, 0, 0);
    exp_pc = 32'h0; pend = 1'b0; pend_addr = 32'h0; hold = 1'b0; hold_pc = 32'h0;
    n_consumed = 0;
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (pend) begin
        chk("rnd.req_held", {31'd0, imem_req}, 32'd1);
        chk("rnd.addr_stable", imem_addr, pend_addr);
      end
      if (hold) begin
        chk("rnd.hold_valid", {31'd0, inst_valid}, 32'd1);
        chk("rnd.hold_pc", pc, hold_pc);
      end
      if (inst_valid) begin
        chk("rnd.data", inst_data, mem_word(pc));
        chk("rnd.pc4", pc_plus4, pc + 32'd4);
      end
      stall    = ($urandom_range(0, 9) < 3);
      redirect = ($urandom_range(0, 19) == 0);
      redirect_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom_range(0, 255) << 2);
      imem_ack = imem_req && ($urandom_range(0, 2) != 0);
      cons = inst_valid && !stall;
      if (redirect) begin
        exp_pc = redirect_pc;
      end else if (cons) begin
        chk("rnd.stream_pc", pc, exp_pc);
        exp_pc = exp_pc + 32'd4;
        n_consumed++;
      end
      pend      = imem_req && !imem_ack;
      pend_addr = imem_addr;
      hold      = inst_valid && stall && !redirect;
      hold_pc   = pc;
      @(posedge clk);
      @(negedge clk);
    end
    chk("rnd.progress", {31'd0, (n_consumed > 300)}, 32'd1);
    chk("rnd.misalign", {31'd0, misalign}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
